// File: rtl/keybuf_pkg.sv
// Shared constants and helpers for the key-entry buffer.
package keybuf_pkg;

  localparam int KEY_W = 4;

  function automatic int cnt_w(input int digits);
    return $clog2(digits + 1);
  endfunction

endpackage

// File: rtl/keybuf_n_key_edge.sv
// Key press edge detector: one event per press of the key level.
module key_edge (
  input  logic clock,
  input  logic reset,
  input  logic key_in,
  output logic key_event
);

  logic key_in_d;

  // Resets high so a key held through reset is not taken as a press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) key_in_d <= 1'b1;
    else        key_in_d <= key_in;
  end

  assign key_event = key_in & ~key_in_d;

endmodule

// File: rtl/keybuf_n.sv
// Parametrised key-entry buffer: shift-in digits, backspace,
// parallel load, digit counter and overflow policy.
module keybuf_n
  import keybuf_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int DECIMAL  = 0,
  parameter int SATURATE = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      key_in,
  input  logic [KEY_W-1:0]          key_val,
  input  logic                      clear,
  input  logic                      bksp,
  input  logic                      load,
  input  logic [DIGITS*KEY_W-1:0]   load_val,
  output logic [DIGITS*KEY_W-1:0]   out,
  output logic [cnt_w(DIGITS)-1:0]  count,
  output logic                      full,
  output logic                      ack
);

  localparam int OW = DIGITS * KEY_W;
  localparam int CW = cnt_w(DIGITS);
  localparam logic [CW-1:0] MAXC = CW'(DIGITS);

  logic          key_event;
  logic          allowed;
  logic          accept;
  logic [OW+KEY_W-1:0] ext;

  key_edge u_edge (
    .clock     (clock),
    .reset     (reset),
    .key_in    (key_in),
    .key_event (key_event)
  );

  // Widened so the shift also works for a single-digit buffer.
  assign ext     = {out, key_val};
  assign full    = (count == MAXC);
  assign allowed = (DECIMAL == 0) || (key_val <= 4'd9);
  assign accept  = key_event && allowed && !((SATURATE != 0) && full);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out   <= '0;
      count <= '0;
      ack   <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (clear) begin
        out   <= '0;
        count <= '0;
      end else if (load) begin
        out   <= load_val;
        count <= MAXC;
      end else if (bksp) begin
        if (count != '0) begin
          out   <= out >> KEY_W;
          count <= count - CW'(1);
        end
      end else if (accept) begin
        out <= ext[OW-1:0];
        ack <= 1'b1;
        if (!full) count <= count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_keybuf_n.sv
// Scoreboard bench: three configurations share stimulus and are
// compared every cycle against a behavioural model.
module tb_keybuf_n;

  typedef struct packed {
    logic [31:0] out;
    logic [3:0]  cnt;
    logic        full;
    logic        ack;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        key_in = 1'b1;
  logic [3:0]  key_val = 4'd5;
  logic        clear = 1'b0;
  logic        bksp = 1'b0;
  logic        load = 1'b0;
  logic [31:0] load_val = '0;

  logic [31:0] o_out [3];
  logic [3:0]  o_cnt [3];
  logic        o_full [3];
  logic        o_ack [3];

  int vectors = 0;
  int miscompares = 0;
  int acks [3] = '{0, 0, 0};

  // model state; index 0 plain, 1 decimal, 2 saturate
  logic [31:0] m_out [3];
  logic [3:0]  m_cnt [3];
  logic        m_kd [3];
  logic        m_ack [3];
  bit          c_dec [3] = '{0, 1, 0};
  bit          c_sat [3] = '{0, 0, 1};

  exp_t sb [$];

  always #5 clock = ~clock;

  keybuf_n #(.DIGITS(8), .DECIMAL(0), .SATURATE(0)) u_dut (
    .clock(clock), .reset(reset), .key_in(key_in), .key_val(key_val),
    .clear(clear), .bksp(bksp), .load(load), .load_val(load_val),
    .out(o_out[0]), .count(o_cnt[0]), .full(o_full[0]), .ack(o_ack[0])
  );

  keybuf_n #(.DIGITS(8), .DECIMAL(1), .SATURATE(0)) u_dec (
    .clock(clock), .reset(reset), .key_in(key_in), .key_val(key_val),
    .clear(clear), .bksp(bksp), .load(load), .load_val(load_val),
    .out(o_out[1]), .count(o_cnt[1]), .full(o_full[1]), .ack(o_ack[1])
  );

  keybuf_n #(.DIGITS(8), .DECIMAL(0), .SATURATE(1)) u_sat (
    .clock(clock), .reset(reset), .key_in(key_in), .key_val(key_val),
    .clear(clear), .bksp(bksp), .load(load), .load_val(load_val),
    .out(o_out[2]), .count(o_cnt[2]), .full(o_full[2]), .ack(o_ack[2])
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_out[i] = '0; m_cnt[i] = '0; m_kd[i] = 1'b1; m_ack[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i);
    bit ev, acc;
    ev  = key_in && !m_kd[i];
    acc = ev && !(c_dec[i] && key_val > 4'd9) && !(c_sat[i] && m_cnt[i] == 4'd8);
    m_ack[i] = 1'b0;
    if (clear) begin
      m_out[i] = '0; m_cnt[i] = '0;
    end else if (load) begin
      m_out[i] = load_val; m_cnt[i] = 4'd8;
    end else if (bksp) begin
      if (m_cnt[i] != 0) begin
        m_out[i] = m_out[i] >> 4; m_cnt[i] = m_cnt[i] - 4'd1;
      end
    end else if (acc) begin
      m_out[i] = {m_out[i][27:0], key_val};
      if (m_cnt[i] < 4'd8) m_cnt[i] = m_cnt[i] + 4'd1;
      m_ack[i] = 1'b1;
    end
    m_kd[i] = key_in;
  endtask

  task automatic tick();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      model_step(i);
      e.out = m_out[i]; e.cnt = m_cnt[i];
      e.full = (m_cnt[i] == 4'd8); e.ack = m_ack[i];
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      check($sformatf("out%0d", i), 64'(o_out[i]), 64'(e.out));
      check($sformatf("cnt%0d", i), 64'(o_cnt[i]), 64'(e.cnt));
      check($sformatf("full%0d", i), 64'(o_full[i]), 64'(e.full));
      check($sformatf("ack%0d", i), 64'(o_ack[i]), 64'(e.ack));
      if (o_ack[i]) acks[i]++;
    end
  endtask

  task automatic press(input logic [3:0] v);
    key_in = 1'b1; key_val = v; tick();
    key_in = 1'b0; tick();
  endtask

  task automatic strobe(input bit c, input bit l, input bit b);
    clear = c; load = l; bksp = b; tick();
    clear = 0; load = 0; bksp = 0;
  endtask

  initial begin
    model_reset();
    #12;
    for (int i = 0; i < 3; i++) begin
      check("rst_out", 64'(o_out[i]), 64'h0);
      check("rst_ack", 64'(o_ack[i]), 64'h0);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (3) tick();
    check("held_out", 64'(o_out[0]), 64'h0);
    check("held_cnt", 64'(o_cnt[0]), 64'h0);
    key_in = 1'b0; tick();

    for (int i = 0; i < 3; i++) acks[i] = 0;
    for (int k = 1; k <= 9; k++) press(4'(k));
    check("shift_out", 64'(o_out[0]), 64'h23456789);
    check("shift_cnt", 64'(o_cnt[0]), 64'd8);
    check("shift_full", 64'(o_full[0]), 64'd1);
    check("shift_acks", 64'(acks[0]), 64'd9);
    check("sat_out", 64'(o_out[2]), 64'h12345678);
    check("sat_acks", 64'(acks[2]), 64'd8);

    strobe(1, 0, 0);
    key_in = 1'b1; key_val = 4'hA; tick();
    check("dec_a_ack", 64'(o_ack[1]), 64'd0);
    key_in = 1'b0; tick();
    check("dec_a_out", 64'(o_out[1]), 64'h0);
    press(4'd7);
    check("dec_7_out", 64'(o_out[1]), 64'h7);
    check("dec_7_cnt", 64'(o_cnt[1]), 64'd1);

    strobe(1, 0, 0);
    press(4'd1); press(4'd2); press(4'd3);
    check("pre_bksp", 64'(o_out[0]), 64'h123);
    strobe(0, 0, 1);
    check("bksp_out", 64'(o_out[0]), 64'h12);
    check("bksp_cnt", 64'(o_cnt[0]), 64'd2);
    repeat (3) strobe(0, 0, 1);
    check("bksp_empty_out", 64'(o_out[0]), 64'h0);
    check("bksp_empty_cnt", 64'(o_cnt[0]), 64'd0);

    press(4'd6);
    key_in = 1'b1; key_val = 4'd4; load_val = 32'hDEADBEEF;
    strobe(1, 1, 0);
    check("pri_clr_out", 64'(o_out[0]), 64'h0);
    check("pri_clr_cnt", 64'(o_cnt[0]), 64'd0);
    check("pri_clr_ack", 64'(o_ack[0]), 64'd0);
    key_in = 1'b0; tick();
    key_in = 1'b1;
    strobe(0, 1, 0);
    check("pri_ld_out", 64'(o_out[0]), 64'hDEADBEEF);
    check("pri_ld_cnt", 64'(o_cnt[0]), 64'd8);
    check("pri_ld_ack", 64'(o_ack[0]), 64'd0);
    key_in = 1'b0; tick();

    for (int n = 0; n < 400; n++) begin
      key_in   = 1'($urandom_range(0, 1));
      key_val  = 4'($urandom);
      clear    = ($urandom_range(0, 15) == 0);
      load     = ($urandom_range(0, 15) == 0);
      bksp     = ($urandom_range(0, 7) == 0);
      load_val = $urandom;
      tick();
      if (n == 200) begin
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
          check("async_out", 64'(o_out[i]), 64'h0);
          check("async_cnt", 64'(o_cnt[i]), 64'h0);
        end
        model_reset();
        reset = 1'b1;
      end
    end
    clear = 0; load = 0; bksp = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keybuf_n.md
# keybuf_n

Parametrised key-entry buffer: successor to the fixed 8-digit hex key buffer. It collects 4-bit key codes from the key encoder into a DIGITS-wide register, newest digit in the least significant nibble. Adds rising-edge key acceptance, backspace, parallel load, a digit counter, a full flag, a decimal-only mode and a selectable overflow policy. It sits between the key encoder and the display/operand registers of the front panel.

## Interface
Parameters:
- DIGITS, 8: number of 4-bit digits held; valid range 1..16.
- DECIMAL, 0: 1 = key_val > 9 is ignored (not accepted, no ack).
- SATURATE, 0: 0 = when full, a new key shifts the oldest digit out; 1 = when full, new keys are ignored.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- key_in  in  1  level, high while any key is held.
- key_val  in  4  code of the held key, valid while key_in = 1.
- clear  in  1  one-cycle strobe: empty the buffer.
- bksp  in  1  one-cycle strobe: delete newest digit.
- load  in  1  one-cycle strobe: load load_val.
- load_val  in  DIGITS*4  parallel load value.
- out  out  DIGITS*4  buffer contents.
- count  out  $clog2(DIGITS+1)  digits entered, 0..DIGITS.
- full  out  1  count == DIGITS.
- ack  out  1  one-cycle pulse: a key was accepted.

## Operation
- Key event: key_in = 1 this cycle and key_in_d = 0, where key_in_d is key_in registered. Holding a key gives exactly one event.
- Key accepted if event, DECIMAL allows key_val, and not (SATURATE = 1 and full).
- Accepted key: out <= {out[DIGITS*4-5:0], key_val}; count <= min(count+1, DIGITS). Shift-out mode: oldest digit is discarded, count stays DIGITS.
- Leading zero keys count as digits.
- bksp: out <= out >> 4 (zero fill at top); count <= max(count-1, 0). On empty buffer: no change.
- load: out <= load_val; count <= DIGITS.
- clear: out <= 0; count <= 0.
- Priority per cycle: clear > load > bksp > key event. A key event losing to a strobe is dropped, not deferred. key_in_d still updates.
- ack is high in the cycle after the edge that accepted a key. It is never set by strobes or rejected keys.
- full is combinational from count.

## Timing
- Reset (reset = 0, asynchronous): out = 0, count = 0, full = 0, ack = 0, key_in_d = 1.
  - Because key_in_d resets to 1, a key still held when reset deasserts is not accepted.
- Latency: out and count reflect an accepted key or strobe one clock edge after the cycle it is sampled.
- Back-to-back: a new key event needs key_in low for at least one sampled cycle between presses.
- Strobes may be asserted on consecutive cycles; each acts independently.
- Reset asserted mid-operation clears all state immediately, regardless of clock.

## Structure
- Shared package keybuf_pkg:
  - KEY_W = 4.
  - Count-width function used for count (clog2 of DIGITS+1).
- Sub-module key_edge: registers key_in (reset value 1) and outputs the one-cycle key event. Instantiated once.
- Remaining logic is in keybuf_n: one priority-ordered sequential block for out, count and ack.

## Test plan
- Reset release with key_in held high, key_val = 5: no acceptance; out = 0, count = 0, ack = 0.
- DIGITS = 8, SATURATE = 0: press 1..9 as separate presses.
  - out = 32'h23456789, count = 8, full = 1.
  - Nine ack pulses total.
- DIGITS = 8, SATURATE = 1: press 1..9 as separate presses.
  - out = 32'h12345678.
  - Ninth press gives no ack.
- DECIMAL = 1:
  - Press A: out unchanged, no ack.
  - Then press 7: out = 7, count = 1.
- Backspace: from out = 32'h00000123, count = 3:
  - bksp gives out = 32'h00000012, count = 2.
  - Three further bksp give out = 0, count = 0 with no underflow.
- Priority, asserted in the same cycle:
  - clear + load + key edge: out = 0, count = 0, ack = 0.
  - load (load_val = 32'hDEADBEEF) + key edge: out = 32'hDEADBEEF, count = 8, no ack.
